// File: rtl/inst_dispatch_router_pkg.sv
// Shared widths, FU index width helper and the buffered dispatch entry type
// for the instruction dispatch router.
package dispatch_pkg;

  localparam int INST_ID_BITS = 6;
  localparam int PRN_BITS     = 6;
  localparam int MAX_OPERANDS = 3;
  localparam int FU_COUNT     = 4;

  function automatic int fuc_bits(input int n);
    return (n > 32'sd1) ? $clog2(n) : 32'sd1;
  endfunction

  localparam int FUC_BITS  = fuc_bits(FU_COUNT);
  localparam int PRN_COUNT = 32'd1 << PRN_BITS;

  typedef struct packed {
    logic [FUC_BITS-1:0]                      fu_sel;
    logic [INST_ID_BITS-1:0]                  inst_id;
    logic [31:0]                              raw_instr;
    logic [63:0]                              pc;
    logic [MAX_OPERANDS-1:0]                  src_valid;
    logic [MAX_OPERANDS-1:0][PRN_BITS-1:0]    src_prn;
    logic [MAX_OPERANDS-1:0]                  dst_valid;
    logic [MAX_OPERANDS-1:0][PRN_BITS-1:0]    dst_prn;
  } dispatch_entry_t;

endpackage

// File: rtl/inst_dispatch_router_if.sv
// FU-queue dispatch bus: per-queue valid/ready plus the head-entry fields
// shared by every queue.
interface inst_dispatch_router_if;
  import dispatch_pkg::*;

  logic [FU_COUNT-1:0]                     inst_valid;
  logic [FU_COUNT-1:0]                     queue_ready;
  logic [INST_ID_BITS-1:0]                 inst_id;
  logic [31:0]                             raw_instr;
  logic [63:0]                             instr_pc;
  logic [MAX_OPERANDS-1:0]                 prn_input_valid;
  logic [MAX_OPERANDS-1:0][PRN_BITS-1:0]   prn_input;
  logic [MAX_OPERANDS-1:0]                 prn_output_valid;
  logic [MAX_OPERANDS-1:0][PRN_BITS-1:0]   prn_output;
  logic [MAX_OPERANDS-1:0]                 prn_input_ready;

  modport master (
    output inst_valid, inst_id, raw_instr, instr_pc,
    output prn_input_valid, prn_input, prn_output_valid, prn_output,
    output prn_input_ready,
    input  queue_ready
  );

  modport slave (
    input  inst_valid, inst_id, raw_instr, instr_pc,
    input  prn_input_valid, prn_input, prn_output_valid, prn_output,
    input  prn_input_ready,
    output queue_ready
  );

endinterface

// File: rtl/inst_dispatch_router_prn_ready_table.sv
// PRN ready-bit table: writeback broadcasts set bits, dispatched destinations
// clear them (clear wins), lookups see same-cycle broadcasts.
module prn_ready_table
  import dispatch_pkg::*;
(
  input  logic                                         clk,
  input  logic                                         rst,
  input  logic [FU_COUNT-1:0][MAX_OPERANDS-1:0]        set_valid,
  input  logic [FU_COUNT-1:0][MAX_OPERANDS-1:0][PRN_BITS-1:0] set_prn,
  input  logic [MAX_OPERANDS-1:0]                      clr_valid,
  input  logic [MAX_OPERANDS-1:0][PRN_BITS-1:0]        clr_prn,
  input  logic [MAX_OPERANDS-1:0]                      lookup_valid,
  input  logic [MAX_OPERANDS-1:0][PRN_BITS-1:0]        lookup_prn,
  output logic [MAX_OPERANDS-1:0]                      lookup_ready
);

  logic [PRN_COUNT-1:0] r_table;
  logic [PRN_COUNT-1:0] w_table_next;
  logic                 w_hit;

  // Sets are applied first so a clear on the same PRN overrides them.
  always_comb begin
    w_table_next = r_table;
    for (int f = 0; f < FU_COUNT; f++) begin
      for (int k = 0; k < MAX_OPERANDS; k++) begin
        w_table_next[set_prn[f][k]] = w_table_next[set_prn[f][k]] | set_valid[f][k];
      end
    end
    for (int k = 0; k < MAX_OPERANDS; k++) begin
      w_table_next[clr_prn[k]] = w_table_next[clr_prn[k]] & ~clr_valid[k];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_table <= '1;
    end else begin
      r_table <= w_table_next;
    end
  end

  // Lookup with bypass from broadcasts arriving this cycle.
  always_comb begin
    lookup_ready = '0;
    w_hit        = 1'b0;
    for (int k = 0; k < MAX_OPERANDS; k++) begin
      w_hit = 1'b0;
      for (int f = 0; f < FU_COUNT; f++) begin
        for (int j = 0; j < MAX_OPERANDS; j++) begin
          w_hit = w_hit | (set_valid[f][j] & (set_prn[f][j] == lookup_prn[k]));
        end
      end
      lookup_ready[k] = lookup_valid[k] & (r_table[lookup_prn[k]] | w_hit);
    end
  end

endmodule

// File: rtl/inst_dispatch_router.sv
// Dispatch router: 2-entry in-order buffer steering its head to one FU issue
// queue. Define DISPATCH_STATS_EN to add saturating dispatch/stall counters.
module inst_dispatch_router
  import dispatch_pkg::*;
(
  input  logic                                         clk,
  input  logic                                         rst,
  input  logic                                         flush,
  input  logic                                         in_valid,
  output logic                                         in_ready,
  input  logic [FUC_BITS-1:0]                          in_fu_sel,
  input  logic [INST_ID_BITS-1:0]                      in_inst_id,
  input  logic [31:0]                                  in_raw_instr,
  input  logic [63:0]                                  in_instr_pc,
  input  logic [MAX_OPERANDS-1:0]                      in_prn_input_valid,
  input  logic [MAX_OPERANDS-1:0][PRN_BITS-1:0]        in_prn_input,
  input  logic [MAX_OPERANDS-1:0]                      in_prn_output_valid,
  input  logic [MAX_OPERANDS-1:0][PRN_BITS-1:0]        in_prn_output,
  input  logic [FU_COUNT-1:0][MAX_OPERANDS-1:0]        set_prn_ready,
  input  logic [FU_COUNT-1:0][MAX_OPERANDS-1:0][PRN_BITS-1:0] set_prn,
`ifdef DISPATCH_STATS_EN
  output logic [31:0]                                  dispatch_count,
  output logic [31:0]                                  stall_cycles,
`endif
  inst_dispatch_router_if.master                       dq
);

  dispatch_entry_t         r_mem [2];
  logic                    r_head;
  logic                    r_tail;
  logic [1:0]              r_count;

  dispatch_entry_t         w_head;
  dispatch_entry_t         w_in_entry;
  logic [FU_COUNT-1:0]     w_inst_valid;
  logic                    w_accept;
  logic                    w_fire;
  logic [MAX_OPERANDS-1:0] w_clr_valid;

  assign in_ready = (r_count < 2'd2);
  assign w_head   = r_mem[r_head];
  assign w_accept = in_valid & in_ready & ~flush;

  always_comb begin
    w_in_entry           = '0;
    w_in_entry.fu_sel    = in_fu_sel;
    w_in_entry.inst_id   = in_inst_id;
    w_in_entry.raw_instr = in_raw_instr;
    w_in_entry.pc        = in_instr_pc;
    w_in_entry.src_valid = in_prn_input_valid;
    w_in_entry.src_prn   = in_prn_input;
    w_in_entry.dst_valid = in_prn_output_valid;
    w_in_entry.dst_prn   = in_prn_output;
  end

  // Head steering: exactly one queue sees valid while anything is buffered.
  always_comb begin
    w_inst_valid = '0;
    if (r_count != 2'd0) begin
      w_inst_valid[w_head.fu_sel] = 1'b1;
    end else begin
      w_inst_valid = '0;
    end
  end

  assign w_fire      = |(w_inst_valid & dq.queue_ready);
  assign w_clr_valid = w_head.dst_valid & {MAX_OPERANDS{w_fire}};

  // Flush empties the buffer; a head that fires on the flush edge is still gone.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_head   <= 1'b0;
      r_tail   <= 1'b0;
      r_count  <= 2'd0;
      r_mem[0] <= '0;
      r_mem[1] <= '0;
    end else if (flush) begin
      r_head  <= 1'b0;
      r_tail  <= 1'b0;
      r_count <= 2'd0;
    end else begin
      if (w_accept) begin
        r_mem[r_tail] <= w_in_entry;
        r_tail        <= ~r_tail;
      end
      if (w_fire) begin
        r_head <= ~r_head;
      end
      r_count <= r_count + {1'b0, w_accept} - {1'b0, w_fire};
    end
  end

  assign dq.inst_valid       = w_inst_valid;
  assign dq.inst_id          = w_head.inst_id;
  assign dq.raw_instr        = w_head.raw_instr;
  assign dq.instr_pc         = w_head.pc;
  assign dq.prn_input_valid  = w_head.src_valid;
  assign dq.prn_input        = w_head.src_prn;
  assign dq.prn_output_valid = w_head.dst_valid;
  assign dq.prn_output       = w_head.dst_prn;

  prn_ready_table u_ready_table (
    .clk          (clk),
    .rst          (rst),
    .set_valid    (set_prn_ready),
    .set_prn      (set_prn),
    .clr_valid    (w_clr_valid),
    .clr_prn      (w_head.dst_prn),
    .lookup_valid (w_head.src_valid),
    .lookup_prn   (w_head.src_prn),
    .lookup_ready (dq.prn_input_ready)
  );

`ifdef DISPATCH_STATS_EN
  logic [31:0] r_dispatch_count;
  logic [31:0] r_stall_cycles;

  // Saturating counters; flush leaves them alone.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_dispatch_count <= 32'd0;
      r_stall_cycles   <= 32'd0;
    end else begin
      if (w_fire && (r_dispatch_count != 32'hFFFF_FFFF)) begin
        r_dispatch_count <= r_dispatch_count + 32'd1;
      end
      if ((r_count != 2'd0) && !w_fire && (r_stall_cycles != 32'hFFFF_FFFF)) begin
        r_stall_cycles <= r_stall_cycles + 32'd1;
      end
    end
  end

  assign dispatch_count = r_dispatch_count;
  assign stall_cycles   = r_stall_cycles;
`endif

endmodule

// File: tb/tb_inst_dispatch_router.sv
// Scoreboard bench for inst_dispatch_router: directed offers push expected
// dispatches; a negedge monitor pops and checks each one as it fires.
module tb_inst_dispatch_router;
  import dispatch_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst;
  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic [1:0]       in_fu_sel;
  logic [5:0]       in_inst_id;
  logic [31:0]      in_raw_instr;
  logic [63:0]      in_instr_pc;
  logic [2:0]       in_prn_input_valid;
  logic [2:0][5:0]  in_prn_input;
  logic [2:0]       in_prn_output_valid;
  logic [2:0][5:0]  in_prn_output;
  logic [3:0][2:0]  set_prn_ready;
  logic [3:0][2:0][5:0] set_prn;
`ifdef DISPATCH_STATS_EN
  logic [31:0]      dispatch_count;
  logic [31:0]      stall_cycles;
`endif

  inst_dispatch_router_if dif ();

  inst_dispatch_router dut (
    .clk                 (clk),
    .rst                 (rst),
    .flush               (flush),
    .in_valid            (in_valid),
    .in_ready            (in_ready),
    .in_fu_sel           (in_fu_sel),
    .in_inst_id          (in_inst_id),
    .in_raw_instr        (in_raw_instr),
    .in_instr_pc         (in_instr_pc),
    .in_prn_input_valid  (in_prn_input_valid),
    .in_prn_input        (in_prn_input),
    .in_prn_output_valid (in_prn_output_valid),
    .in_prn_output       (in_prn_output),
    .set_prn_ready       (set_prn_ready),
    .set_prn             (set_prn),
`ifdef DISPATCH_STATS_EN
    .dispatch_count      (dispatch_count),
    .stall_cycles        (stall_cycles),
`endif
    .dq                  (dif)
  );

  typedef struct {
    logic [1:0] fu;
    logic [5:0] id;
    logic [2:0] pir;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   m_stall  = 0;
  int   m_disp   = 0;

  function automatic logic [31:0] raw_of(input logic [5:0] id);
    return 32'hC0DE_0000 | {26'd0, id};
  endfunction

  function automatic logic [63:0] pc_of(input logic [5:0] id);
    return 64'h8000_0000 + {56'd0, id, 2'b00};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drives one offer across one clock edge, optionally recording the expected dispatch.
  task automatic offer(input logic [1:0] fu, input logic [5:0] id,
                       input logic [2:0] sv, input logic [17:0] sp,
                       input logic [2:0] dv, input logic [17:0] dp,
                       input logic push, input logic [2:0] pir);
    exp_t e;
    in_valid            = 1'b1;
    in_fu_sel           = fu;
    in_inst_id          = id;
    in_raw_instr        = raw_of(id);
    in_instr_pc         = pc_of(id);
    in_prn_input_valid  = sv;
    in_prn_input        = sp;
    in_prn_output_valid = dv;
    in_prn_output       = dp;
    if (push) begin
      e.fu = fu; e.id = id; e.pir = pir;
      exp_q.push_back(e);
    end
    tick();
    in_valid = 1'b0;
  endtask

  // Monitor: every fire must match the oldest expected dispatch.
  always @(negedge clk) begin
    if (!rst) begin
      m_stall = 0;
      m_disp  = 0;
    end else if (|(dif.inst_valid & dif.queue_ready)) begin
      m_disp++;
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_dispatch: inst_id %0d fired, none expected", dif.inst_id);
      end else begin
        mon_e = exp_q.pop_front();
        chk("disp_valid", {60'd0, dif.inst_valid}, 64'd1 << mon_e.fu);
        chk("disp_id", {58'd0, dif.inst_id}, {58'd0, mon_e.id});
        chk("disp_raw", {32'd0, dif.raw_instr}, {32'd0, raw_of(mon_e.id)});
        chk("disp_pc", dif.instr_pc, pc_of(mon_e.id));
        chk("disp_pir", {61'd0, dif.prn_input_ready}, {61'd0, mon_e.pir});
      end
    end else if (|dif.inst_valid) begin
      m_stall++;
    end
  end

  initial begin
    rst = 1'b0; flush = 1'b0; in_valid = 1'b0;
    in_fu_sel = 2'd0; in_inst_id = 6'd0; in_raw_instr = 32'd0; in_instr_pc = 64'd0;
    in_prn_input_valid = 3'd0; in_prn_input = '0;
    in_prn_output_valid = 3'd0; in_prn_output = '0;
    set_prn_ready = '0; set_prn = '0;
    dif.queue_ready = 4'd0;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_inst_valid", {60'd0, dif.inst_valid}, 64'd0);
    chk("rst_in_ready", {63'd0, in_ready}, 64'd1);
    rst = 1'b1;
    tick();
    chk("post_rst_in_ready", {63'd0, in_ready}, 64'd1);
    chk("post_rst_inst_valid", {60'd0, dif.inst_valid}, 64'd0);
`ifdef DISPATCH_STATS_EN
    chk("rst_dispatch_count", {32'd0, dispatch_count}, 64'd0);
    chk("rst_stall_cycles", {32'd0, stall_cycles}, 64'd0);
`endif

    // single instruction to FU 2, src0 = 5
    offer(2'd2, 6'd1, 3'b001, {6'd0, 6'd0, 6'd5}, 3'b000, 18'd0, 1'b1, 3'b001);
    chk("t1_inst_valid", {60'd0, dif.inst_valid}, 64'h4);
    chk("t1_pir", {61'd0, dif.prn_input_ready}, 64'h1);
    dif.queue_ready = 4'b0100;
    tick();
    dif.queue_ready = 4'b0000;
    chk("t1_drained", {60'd0, dif.inst_valid}, 64'd0);

    // destination clear, then broadcast bypass and table set
    offer(2'd1, 6'd2, 3'b000, 18'd0, 3'b001, {6'd0, 6'd0, 6'd9}, 1'b1, 3'b000);
    dif.queue_ready = 4'b0010;
    tick();
    dif.queue_ready = 4'b0000;
    offer(2'd3, 6'd3, 3'b001, {6'd0, 6'd0, 6'd9}, 3'b000, 18'd0, 1'b1, 3'b001);
    chk("t2_src_cleared", {61'd0, dif.prn_input_ready}, 64'h0);
    set_prn_ready[1][0] = 1'b1;
    set_prn[1][0] = 6'd9;
    #1;
    chk("t2_bypass", {61'd0, dif.prn_input_ready}, 64'h1);
    tick();
    set_prn_ready = '0;
    set_prn = '0;
    #1;
    chk("t2_table_set", {61'd0, dif.prn_input_ready}, 64'h1);
    dif.queue_ready = 4'b1000;
    tick();
    dif.queue_ready = 4'b0000;

    // backpressure: third offer refused, head stable, other queues ignored
    offer(2'd0, 6'd4, 3'b001, {6'd0, 6'd0, 6'd9}, 3'b000, 18'd0, 1'b1, 3'b001);
    offer(2'd0, 6'd5, 3'b000, 18'd0, 3'b000, 18'd0, 1'b1, 3'b000);
    chk("t3_full_in_ready", {63'd0, in_ready}, 64'd0);
    offer(2'd0, 6'd6, 3'b000, 18'd0, 3'b000, 18'd0, 1'b0, 3'b000);
    chk("t3_still_full", {63'd0, in_ready}, 64'd0);
    dif.queue_ready = 4'b1110;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("t3_stable_id", {58'd0, dif.inst_id}, 64'd4);
      chk("t3_stable_valid", {60'd0, dif.inst_valid}, 64'h1);
    end
    dif.queue_ready = 4'b0001;
    tick();
    tick();
    dif.queue_ready = 4'b0000;
    chk("t3_drained_valid", {60'd0, dif.inst_valid}, 64'd0);
    chk("t3_drained_ready", {63'd0, in_ready}, 64'd1);

    // set/clear race on PRN 12: clear wins
    offer(2'd2, 6'd7, 3'b000, 18'd0, 3'b001, {6'd0, 6'd0, 6'd12}, 1'b1, 3'b000);
    dif.queue_ready = 4'b0100;
    set_prn_ready[0][1] = 1'b1;
    set_prn[0][1] = 6'd12;
    tick();
    dif.queue_ready = 4'b0000;
    set_prn_ready = '0;
    set_prn = '0;
    offer(2'd2, 6'd8, 3'b010, {6'd0, 6'd12, 6'd0}, 3'b000, 18'd0, 1'b1, 3'b000);
    chk("t4_clear_wins", {61'd0, dif.prn_input_ready}, 64'h0);
    dif.queue_ready = 4'b0100;
    tick();
    dif.queue_ready = 4'b0000;

    // accept and fire on the same edge with one entry buffered
    dif.queue_ready = 4'b1000;
    offer(2'd3, 6'd12, 3'b000, 18'd0, 3'b000, 18'd0, 1'b1, 3'b000);
    offer(2'd3, 6'd13, 3'b000, 18'd0, 3'b000, 18'd0, 1'b1, 3'b000);
    chk("t5_count_one", {63'd0, in_ready}, 64'd1);
    chk("t5_head13", {58'd0, dif.inst_id}, 64'd13);
    tick();
    dif.queue_ready = 4'b0000;
    chk("t5_drained", {60'd0, dif.inst_valid}, 64'd0);

    // flush while full, and flush overriding an accept at count 1
    offer(2'd1, 6'd20, 3'b000, 18'd0, 3'b000, 18'd0, 1'b0, 3'b000);
    offer(2'd1, 6'd21, 3'b000, 18'd0, 3'b000, 18'd0, 1'b0, 3'b000);
    flush = 1'b1;
    offer(2'd1, 6'd22, 3'b000, 18'd0, 3'b000, 18'd0, 1'b0, 3'b000);
    flush = 1'b0;
    chk("t6_flush_valid", {60'd0, dif.inst_valid}, 64'd0);
    chk("t6_flush_ready", {63'd0, in_ready}, 64'd1);
    offer(2'd1, 6'd23, 3'b000, 18'd0, 3'b000, 18'd0, 1'b0, 3'b000);
    flush = 1'b1;
    offer(2'd1, 6'd24, 3'b000, 18'd0, 3'b000, 18'd0, 1'b0, 3'b000);
    flush = 1'b0;
    chk("t6_flush_drop_accept", {60'd0, dif.inst_valid}, 64'd0);
    dif.queue_ready = 4'b1111;
    tick();
    tick();
    dif.queue_ready = 4'b0000;

    // asynchronous reset during a stall
    offer(2'd0, 6'd30, 3'b011, {6'd0, 6'd9, 6'd12}, 3'b000, 18'd0, 1'b0, 3'b000);
    chk("t7_pir", {61'd0, dif.prn_input_ready}, 64'h2);
    repeat (4) tick();
`ifdef DISPATCH_STATS_EN
    chk("t7_stall_cycles", {32'd0, stall_cycles}, 64'(m_stall));
    chk("t7_dispatch_count", {32'd0, dispatch_count}, 64'(m_disp));
`endif
    #1 rst = 1'b0;
    #1;
    chk("t7_async_valid", {60'd0, dif.inst_valid}, 64'd0);
    chk("t7_async_ready", {63'd0, in_ready}, 64'd1);
`ifdef DISPATCH_STATS_EN
    chk("t7_stall_reset", {32'd0, stall_cycles}, 64'd0);
`endif
    tick();
    rst = 1'b1;
    offer(2'd0, 6'd31, 3'b111, {6'd13, 6'd9, 6'd12}, 3'b000, 18'd0, 1'b1, 3'b111);
    chk("t7_table_all_ones", {61'd0, dif.prn_input_ready}, 64'h7);
    dif.queue_ready = 4'b0001;
    tick();
    dif.queue_ready = 4'b0000;
    tick();

    chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/inst_dispatch_router.md
Name: inst_dispatch_router

Overview:
- Producer side of the FU-queue dispatch interface (inst_valid/queue_ready plus instruction/PRN fields).
- Accepts renamed instructions in order from rename, buffers them in a 2-entry FIFO, and steers the head to exactly one FU issue queue selected by a rename-supplied FU index.
- Owns the PRN ready-bit table: computes the prn_input_ready flags sent with each instruction from FU writeback broadcasts.

Parameters:
INST_ID_BITS, 6, instruction ID width
PRN_BITS, 6, physical register number width; table size 2**PRN_BITS
MAX_OPERANDS, 3, source/destination operand slots per instruction
FU_COUNT, 4, number of FU issue queues; FUC_BITS = $clog2(FU_COUNT)

Ports:
clk  in  1  clock, the only clock
rst  in  1  reset; one clock; reset is asynchronous and active-low
flush  in  1  drop all buffered instructions
in_valid  in  1  rename offers an instruction
in_ready  out  1  router can accept
in_fu_sel  in  FUC_BITS  target FU queue index
in_inst_id  in  INST_ID_BITS  instruction ID
in_raw_instr  in  32  encoded instruction
in_instr_pc  in  64  instruction PC
in_prn_input_valid  in  1 x MAX_OPERANDS  source slot used
in_prn_input  in  PRN_BITS x MAX_OPERANDS  source PRNs
in_prn_output_valid  in  1 x MAX_OPERANDS  destination slot used
in_prn_output  in  PRN_BITS x MAX_OPERANDS  destination PRNs
inst_valid  out  1 x FU_COUNT  per-queue valid, at most one set
queue_ready  in  1 x FU_COUNT  per-queue ready
inst_id, raw_instr, instr_pc, prn_input_valid, prn_input, prn_output_valid, prn_output  out  as inputs  head-entry fields, shared by all queues
prn_input_ready  out  1 x MAX_OPERANDS  source value already in PRF
set_prn_ready  in  1 x FU_COUNT x MAX_OPERANDS  writeback broadcast valid
set_prn  in  PRN_BITS x FU_COUNT x MAX_OPERANDS  writeback broadcast PRN

Behaviour:
- FIFO: 2 entries, registered head/tail pointers and 2-bit count. in_ready = (count < 2), taken from registered count only; no same-cycle bypass.
- Accept: in_valid & in_ready. Minimum latency is 1 cycle: accepted at edge N, visible at the head in cycle N+1.
- Dispatch: when count > 0, inst_valid[head.fu_sel] = 1 and all other bits are 0. Fire = that bit & queue_ready[head.fu_sel].
- Output fields come straight from head storage and are stable while stalled.
- Ready on a non-selected queue has no effect. Head-of-line blocking is strict; there is no reordering.
- Accept and fire in the same cycle with count == 2: not possible, because in_ready = 0 at count 2. With count == 1 both occur and count stays at 1.
- Pointer wrap: 1-bit pointers that toggle.
- Ready table: 2**PRN_BITS bits. All bits are set to 1 on reset.
  - Set phase: on any set_prn_ready[f][k], bit set_prn[f][k] is set.
  - Clear phase: on fire, for each k with prn_output_valid[k], bit prn_output[k] is cleared.
  - If a PRN is both set and cleared in the same edge, clear wins.
- prn_input_ready[k] = prn_input_valid[k] & (table[prn_input[k]] | any same-cycle broadcast matching prn_input[k]). This is a combinational bypass.
- Flush: synchronous. Count and pointers go to 0 and inst_valid goes to 0 next cycle. The ready table is untouched.
  - Flush has priority over a same-cycle accept, which is dropped.
  - A same-cycle fire still goes to the queue.
- Reset values (asynchronous, rst low): count 0, pointers 0, in_ready 1 after release, all inst_valid 0, table all 1s, stored fields 0.
- Reset asserted mid-operation discards buffered entries immediately.

Optional Feature:
- Macro DISPATCH_STATS_EN.
- Defined:
  - Adds output dispatch_count (32-bit), incremented on every fire.
  - Adds output stall_cycles (32-bit), incremented when count > 0 and there is no fire.
  - Both counters saturate at all-ones and reset to 0 by rst. Flush does not clear them.
- Undefined: these ports and counters do not exist; all other behaviour is identical.

Decomposition:
- Package dispatch_pkg holds:
  - the FUC_BITS computation helper;
  - typedef struct dispatch_entry_t (fu_sel, inst_id, raw_instr, pc, source/destination valid and PRN arrays), used for FIFO storage.
- Sub-module prn_ready_table owns:
  - the bit table, set/clear ports with clear priority, and MAX_OPERANDS lookup ports with broadcast bypass.
- The FIFO and steering logic stay in the top module.

Test Plan:
- Reset then one instruction: fu_sel=2, src0=5. Cycle after accept → inst_valid=4'b0100 and prn_input_ready[0]=1. With queue_ready[2]=1 it fires and count returns to 0.
- Dest clear: dispatch with dest PRN 9, then next instruction with src0=9 and no broadcast → prn_input_ready[0]=0. Drive set_prn[1][0]=9 with ready → same cycle prn_input_ready[0]=1, and the table bit stays 1 afterward.
- Backpressure: queue_ready all 0, offer 3 instructions → 2 accepted and in_ready=0. Head fields stay stable for 10 cycles. Releasing the queue drains both in order by inst_id.
- Set/clear race: fire with dest 12 while a broadcast also sets PRN 12 → bit 12 reads 0 the following cycle.
- Flush while count=2 and in_valid=1 → count=0 next cycle, no inst_valid, and the offered instruction is never dispatched.
- Asynchronous reset asserted mid-stall: inst_valid drops before the next clk edge and the table reads all 1s. With DISPATCH_STATS_EN, stall_cycles counts exactly the stalled cycles before the reset.
